enc16to4_low_arb: RTL and testbench

- Reverse direction of the team's active-low 4-to-16 decoder.
- Watches 16 active-low request lines and captures each new assertion (falling edge) into a pending set.
- Serves pending lines one at a time as a 4-bit index over a valid/ready handshake.
- Sits between raw strobe/interrupt lines and any consumer of a binary line code; used in LAB6 loop-back benches with the decoder.

---
 rtl/enc16to4_low_arb_pkg.sv | 10 +
 rtl/enc16to4_low_arb_prio_pick16.sv | 31 +++
 rtl/enc16to4_low_arb.sv | 134 +++++++++++++
 tb/tb_enc16to4_low_arb.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc16to4_low_arb_pkg.sv
// Values shared by the active-low 4-to-16 decoder and this 16-to-4 arbiter/encoder.
package enc_dec_pkg;
    localparam int N_LINES = 16;
    localparam int CODE_W  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;
endpackage

// File: rtl/enc16to4_low_arb_prio_pick16.sv
// Picks the first set bit of a 16-bit mask, either from bit 0 (fixed priority)
// or starting just after 'base' and wrapping (round-robin).
module prio_pick16
    import enc_dec_pkg::*;
(
    input  logic [N_LINES-1:0] mask,
    input  logic [CODE_W-1:0]  base,
    input  logic               rr_en,
    output logic [CODE_W-1:0]  index,
    output logic               found
);

    logic [CODE_W-1:0] start;
    logic [CODE_W-1:0] cand;

    always_comb begin
        start = rr_en ? base + CODE_W'(1) : '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        // Modulo-16 wrap comes for free from the 4-bit candidate arithmetic.
        for (int i = 0; i < N_LINES; i++) begin
            cand = start + CODE_W'(i);
            if (!found && mask[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/enc16to4_low_arb.sv
// Captures falling edges on 16 active-low request lines into a pending set and
// serves them one at a time as a 4-bit code over a valid/ready handshake.
//
// state    | meaning
// ST_IDLE  | nothing offered; waits for en=1 and a non-empty pending set
// ST_OFFER | out_code/out_valid held stable until out_valid && out_ready
module enc16to4_low_arb
    import enc_dec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RR_MODE     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [N_LINES-1:0] req_n,
    output logic [CODE_W-1:0]  out_code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               any_pending,
    output logic               overrun,
    input  logic               ovr_clr
);

    logic [N_LINES-1:0] sync_q [SYNC_STAGES];
    logic [N_LINES-1:0] sync_d [SYNC_STAGES];
    logic [N_LINES-1:0] prev_q, prev_d;
    logic [N_LINES-1:0] pending_q, pending_d;
    logic [CODE_W-1:0]  out_code_q, out_code_d;
    logic [CODE_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic               out_valid_q, out_valid_d;
    logic               any_pending_q, any_pending_d;
    logic               overrun_q, overrun_d;
    state_e             state_q, state_d;

    logic [N_LINES-1:0] fall;
    logic [N_LINES-1:0] acc_mask;
    logic [N_LINES-1:0] pick_mask;
    logic [CODE_W-1:0]  pick_base;
    logic [CODE_W-1:0]  pick_idx;
    logic               pick_found;
    logic               accept;

    prio_pick16 u_pick (
        .mask  (pick_mask),
        .base  (pick_base),
        .rr_en (RR_MODE != 0),
        .index (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        sync_d[0] = req_n;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
        fall   = prev_q & ~sync_q[SYNC_STAGES-1];

        accept    = (state_q == ST_OFFER) && out_ready;
        acc_mask  = accept ? (N_LINES'(1) << out_code_q) : '0;
        // During an accept the next pick excludes the line just served.
        pick_mask = pending_q & ~acc_mask;
        pick_base = accept ? out_code_q : rr_ptr_q;

        pending_d     = (pending_q & ~acc_mask) | (en ? fall : '0);
        any_pending_d = |pending_d;
        overrun_d     = (en && |(fall & pending_q)) || (overrun_q && !ovr_clr);

        state_d     = state_q;
        out_code_d  = out_code_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (en && pick_found) begin
                    state_d     = ST_OFFER;
                    out_code_d  = pick_idx;
                    out_valid_d = 1'b1;
                end
            end
            ST_OFFER: begin
                if (accept) begin
                    rr_ptr_d = out_code_q;
                    if (en && pick_found) begin
                        out_code_d = pick_idx;
                    end else begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
            prev_q        <= '1;
            pending_q     <= '0;
            out_code_q    <= '0;
            out_valid_q   <= 1'b0;
            any_pending_q <= 1'b0;
            overrun_q     <= 1'b0;
            rr_ptr_q      <= '1;
            state_q       <= ST_IDLE;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            prev_q        <= prev_d;
            pending_q     <= pending_d;
            out_code_q    <= out_code_d;
            out_valid_q   <= out_valid_d;
            any_pending_q <= any_pending_d;
            overrun_q     <= overrun_d;
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= state_d;
        end
    end

    assign out_code    = out_code_q;
    assign out_valid   = out_valid_q;
    assign any_pending = any_pending_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_enc16to4_low_arb.sv
// Bench for enc16to4_low_arb: one fixed-priority and one round-robin instance
// driven in parallel, checked against directed expectations and a reference model.
module tb_enc16to4_low_arb;

    localparam int SYNC = 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] req_n;
    logic        out_ready;
    logic        ovr_clr;

    logic [3:0]  o_code0, o_code1;
    logic        o_valid0, o_valid1;
    logic        o_anyp0, o_anyp1;
    logic        o_ovr0, o_ovr1;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = fixed priority, 1 = round-robin
    logic [15:0] hist [SYNC+1];
    logic [15:0] m_pend [2];
    bit          m_off  [2];
    int          m_code [2];
    int          m_ptr  [2];
    bit          m_ovr  [2];
    bit          m_anyp [2];

    enc16to4_low_arb #(.SYNC_STAGES(SYNC), .RR_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .req_n(req_n),
        .out_code(o_code0), .out_valid(o_valid0), .out_ready(out_ready),
        .any_pending(o_anyp0), .overrun(o_ovr0), .ovr_clr(ovr_clr)
    );

    enc16to4_low_arb #(.SYNC_STAGES(SYNC), .RR_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req_n(req_n),
        .out_code(o_code1), .out_valid(o_valid1), .out_ready(out_ready),
        .any_pending(o_anyp1), .overrun(o_ovr1), .ovr_clr(ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(logic [15:0] mask, int mode, int last);
        if (mode == 0) begin
            for (int i = 0; i < 16; i++) if (mask[i]) return i;
        end else begin
            for (int k = 1; k <= 16; k++) if (mask[(last + k) % 16]) return (last + k) % 16;
        end
        return -1;
    endfunction

    function automatic logic [3:0] dcode(int m);
        return (m == 0) ? o_code0 : o_code1;
    endfunction
    function automatic logic dvalid(int m);
        return (m == 0) ? o_valid0 : o_valid1;
    endfunction
    function automatic logic danyp(int m);
        return (m == 0) ? o_anyp0 : o_anyp1;
    endfunction
    function automatic logic dovr(int m);
        return (m == 0) ? o_ovr0 : o_ovr1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s <= SYNC; s++) hist[s] = 16'hFFFF;
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0; m_off[m] = 0; m_code[m] = 0;
            m_ptr[m] = 15;  m_ovr[m] = 0; m_anyp[m] = 0;
        end
    endtask

    // One rising edge: the model consumes the inputs that were stable before it.
    task automatic model_edge();
        logic [15:0] fall, accbit, rem, newp;
        bit acc;
        for (int i = 0; i < 16; i++) fall[i] = hist[SYNC][i] && !hist[SYNC-1][i];
        for (int s = SYNC; s > 0; s--) hist[s] = hist[s-1];
        hist[0] = req_n;
        for (int m = 0; m < 2; m++) begin
            acc    = m_off[m] && out_ready;
            accbit = acc ? (16'h1 << m_code[m]) : 16'h0;
            newp   = (m_pend[m] & ~accbit) | (en ? fall : 16'h0);
            m_ovr[m] = (en && ((fall & m_pend[m]) != 0)) || (m_ovr[m] && !ovr_clr);
            if (!m_off[m]) begin
                if (en && m_pend[m] != 0) begin
                    m_off[m]  = 1;
                    m_code[m] = pick(m_pend[m], m, m_ptr[m]);
                end
            end else if (acc) begin
                m_ptr[m] = m_code[m];
                rem = m_pend[m] & ~accbit;
                if (en && rem != 0) m_code[m] = pick(rem, m, m_ptr[m]);
                else m_off[m] = 0;
            end
            m_pend[m] = newp;
            m_anyp[m] = (newp != 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b1; out_ready = 1'b1; ovr_clr = 1'b0; req_n = 16'hFFFF;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dvalid(m) !== 1'b0 || danyp(m) !== 1'b0 || dovr(m) !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_idle m=%0d cyc=%0d got v/a/o=%0b%0b%0b exp=000",
                             m, c, dvalid(m), danyp(m), dovr(m));
                end
            end
        end
    endtask

    task automatic test_latency();
        req_n = 16'hFFFF; out_ready = 1'b1; en = 1'b1;
        do_reset();
        req_n[5] = 1'b0;
        step(); step();
        step();
        checks++;
        if (o_valid0 !== 1'b0 || o_anyp0 !== 1'b1) begin
            errors++;
            $display("FAIL latency_pend got v=%0b a=%0b exp v=0 a=1", o_valid0, o_anyp0);
        end
        step();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (dvalid(m) !== 1'b1 || dcode(m) !== 4'd5) begin
                errors++;
                $display("FAIL latency_offer m=%0d got v=%0b code=%0d exp v=1 code=5",
                         m, dvalid(m), dcode(m));
            end
        end
        step();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (dvalid(m) !== 1'b0 || danyp(m) !== 1'b0) begin
                errors++;
                $display("FAIL latency_done m=%0d got v=%0b a=%0b exp 0 0", m, dvalid(m), danyp(m));
            end
        end
        req_n = 16'hFFFF;
        step(); step();
    endtask

    task automatic test_stall_b2b();
        int budget;
        int exp_seq [3] = '{3, 9, 12};
        req_n = 16'hFFFF; out_ready = 1'b0; en = 1'b1;
        do_reset();
        req_n[3] = 1'b0; req_n[9] = 1'b0; req_n[12] = 1'b0;
        budget = 0;
        while (!o_valid0 && budget < 10) begin step(); budget++; end
        checks++;
        if (!o_valid0) begin
            errors++;
            $display("FAIL stall_timeout got valid=%0b exp valid=1 within 10 cycles", o_valid0);
        end
        for (int c = 0; c < 5; c++) begin
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dvalid(m) !== 1'b1 || dcode(m) !== 4'd3) begin
                    errors++;
                    $display("FAIL stall_hold m=%0d cyc=%0d got v=%0b code=%0d exp v=1 code=3",
                             m, c, dvalid(m), dcode(m));
                end
            end
            step();
        end
        out_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dvalid(m) !== 1'b1 || dcode(m) !== 4'(exp_seq[k])) begin
                    errors++;
                    $display("FAIL b2b_code m=%0d k=%0d got v=%0b code=%0d exp v=1 code=%0d",
                             m, k, dvalid(m), dcode(m), exp_seq[k]);
                end
            end
        end
        step();
        checks++;
        if (o_valid0 !== 1'b0 || o_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got v0=%0b v1=%0b exp 0 0", o_valid0, o_valid1);
        end
        req_n = 16'hFFFF;
        step(); step();
    endtask

    task automatic test_rr_overrun();
        int acc_q [$];
        int n0, n2;
        req_n = 16'hFFFF; out_ready = 1'b1; en = 1'b1; ovr_clr = 1'b0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            req_n[0] = (c % 2 != 0) || (c >= 16);
            req_n[2] = (c % 2 != 0) || (c >= 16);
            if (o_valid1 && out_ready) acc_q.push_back(int'(o_code1));
            step();
            checks++;
            if (o_valid1 !== m_off[1] || (m_off[1] && o_code1 !== 4'(m_code[1])) || o_ovr1 !== m_ovr[1]) begin
                errors++;
                $display("FAIL rr_model cyc=%0d got v=%0b code=%0d o=%0b exp v=%0b code=%0d o=%0b",
                         c, o_valid1, o_code1, o_ovr1, m_off[1], m_code[1], m_ovr[1]);
            end
        end
        n0 = 0; n2 = 0;
        for (int i = 0; i < acc_q.size(); i++) begin
            if (acc_q[i] == 0) n0++;
            if (acc_q[i] == 2) n2++;
            if (i > 0) begin
                checks++;
                if (acc_q[i] == acc_q[i-1]) begin
                    errors++;
                    $display("FAIL rr_alternate idx=%0d got code=%0d after %0d exp a different line",
                             i, acc_q[i], acc_q[i-1]);
                end
            end
        end
        checks++;
        if (n0 < 3 || n2 < 3) begin
            errors++;
            $display("FAIL rr_starve got n0=%0d n2=%0d exp both >= 3", n0, n2);
        end
        checks++;
        if (o_ovr1 !== 1'b1 || o_ovr0 !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky got o0=%0b o1=%0b exp 1 1", o_ovr0, o_ovr1);
        end
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        checks++;
        if (o_ovr1 !== 1'b0 || o_ovr0 !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear got o0=%0b o1=%0b exp 0 0", o_ovr0, o_ovr1);
        end
    endtask

    task automatic test_enable();
        int budget;
        req_n = 16'hFFFF; out_ready = 1'b1; en = 1'b0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            req_n[7] = !(c < 2 || (c >= 10 && c < 12));
            if (c == 8) en = 1'b1;
            step();
            if (c < 10) begin
                checks++;
                if (o_valid0 !== 1'b0 || o_anyp0 !== 1'b0 || o_valid1 !== 1'b0) begin
                    errors++;
                    $display("FAIL en_drop cyc=%0d got v0=%0b a0=%0b v1=%0b exp 0 0 0",
                             c, o_valid0, o_anyp0, o_valid1);
                end
            end
        end
        budget = 0;
        while (!o_valid0 && budget < 10) begin step(); budget++; end
        checks++;
        if (o_valid0 !== 1'b1 || o_code0 !== 4'd7) begin
            errors++;
            $display("FAIL en_serve got v=%0b code=%0d exp v=1 code=7", o_valid0, o_code0);
        end
        step(); step();
    endtask

    task automatic test_reset_mid_offer();
        int budget;
        req_n = 16'hFFFF; out_ready = 1'b0; en = 1'b1;
        do_reset();
        req_n[10] = 1'b0;
        budget = 0;
        while (!o_valid0 && budget < 10) begin step(); budget++; end
        req_n[4] = 1'b0; req_n[11] = 1'b0;
        repeat (4) step();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (dvalid(m) !== 1'b1 || dcode(m) !== 4'd10 || m_pend[m] !== 16'h0C10) begin
                errors++;
                $display("FAIL mid_setup m=%0d got v=%0b code=%0d exp v=1 code=10 pend=0c10",
                         m, dvalid(m), dcode(m));
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (dvalid(m) !== 1'b0 || danyp(m) !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset m=%0d got v=%0b a=%0b exp 0 0", m, dvalid(m), danyp(m));
            end
        end
        req_n = 16'hFFFF; out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (o_valid0 !== 1'b0 || o_valid1 !== 1'b0 || o_anyp0 !== 1'b0) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got v0=%0b v1=%0b a0=%0b exp 0 0 0",
                         c, o_valid0, o_valid1, o_anyp0);
            end
        end
    endtask

    task automatic test_random();
        req_n = 16'hFFFF; out_ready = 1'b1; en = 1'b1; ovr_clr = 1'b0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req_n     = req_n ^ 16'($urandom & $urandom & $urandom);
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ovr_clr   = ($urandom_range(0, 7) == 0);
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dvalid(m) !== m_off[m] || (m_off[m] && dcode(m) !== 4'(m_code[m])) ||
                    danyp(m) !== m_anyp[m] || dovr(m) !== m_ovr[m]) begin
                    errors++;
                    $display("FAIL rand m=%0d cyc=%0d got v=%0b code=%0d a=%0b o=%0b exp v=%0b code=%0d a=%0b o=%0b",
                             m, c, dvalid(m), dcode(m), danyp(m), dovr(m),
                             m_off[m], m_code[m], m_anyp[m], m_ovr[m]);
                end
            end
        end
        ovr_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req_n = 16'hFFFF; out_ready = 1'b0; ovr_clr = 1'b0;
        model_reset();
        test_reset();
        test_latency();
        test_stall_b2b();
        test_rr_overrun();
        test_enable();
        test_reset_mid_offer();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
